// File: rtl/ctrl_pkg.sv
// Shared encodings for the ARM-subset control path: opcodes, DP commands,
// condition codes, ALU selects, fault FSM states and the decode bundle.
package ctrl_pkg;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_e;

    typedef struct packed {
        logic [1:0] reg_src;
        logic       reg_w;
        logic       mem_w;
        logic [1:0] imm_src;
        logic       alu_src;
        logic [1:0] alu_ctl;
        logic       mem_to_reg;
        logic       branch;
        logic [1:0] flag_w;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/control_unit_cond.sv
// NZCV flag registers, condition evaluation and qualification of the
// architectural write enables (RegWrite, MemWrite, PCSrc, flag update).
module cond_logic
    import ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  cond_e      cond_i,
    input  logic [1:0] flag_w_i,
    input  logic [3:0] alu_flags_i,
    input  logic       run_i,
    input  logic       legal_i,
    input  logic       reg_w_i,
    input  logic       mem_w_i,
    input  logic       pcs_i,
    output logic       cond_ex_o,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic       pc_src_o
);

    logic [3:0] flags_q, flags_d;
    logic       n, z, c, v;
    logic       cond_ex;
    logic       wr_ok;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        unique case (cond_i)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Reset also masks the enables so nothing commits during the reset cycle.
    assign wr_ok       = cond_ex & run_i & legal_i & ~reset;
    assign cond_ex_o   = cond_ex;
    assign reg_write_o = reg_w_i & wr_ok;
    assign mem_write_o = mem_w_i & wr_ok;
    assign pc_src_o    = pcs_i & wr_ok;

    always_comb begin
        flags_d = flags_q;
        if (wr_ok & flag_w_i[1]) flags_d[3:2] = alu_flags_i[3:2];
        if (wr_ok & flag_w_i[0]) flags_d[1:0] = alu_flags_i[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) flags_q <= FLAGS_RST;
        else       flags_q <= flags_d;
    end

endmodule

// File: rtl/control_unit.sv
// Single-cycle ARM-subset control unit: decoder, sticky fault FSM and
// optional perf counters (enabled with `define CTRL_PERF_EN).
module control_unit
    import ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000,
    parameter int         CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrc,
    output logic [1:0]  ALUControl,
    output logic        MemtoReg,
    output logic        MemWrite,
    output logic        PCSrc,
    output logic        fault
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] skipped_cnt
`endif
);

    cond_e      cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;
    dec_t       dec;
    logic       pcs;
    logic       cond_ex;
    logic       run;
    state_e     state_q;
    logic       fault_q;
    logic       unused_rn;

    assign cond      = cond_e'(Instr[19:16]);
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign cmd       = funct[4:1];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    always_comb begin
        dec = '0;
        unique case (op)
            OP_DP: begin
                dec.reg_w   = 1'b1;
                dec.alu_src = funct[5];
                unique case (cmd)
                    CMD_ADD: dec.alu_ctl = ALU_ADD;
                    CMD_SUB: dec.alu_ctl = ALU_SUB;
                    CMD_AND: dec.alu_ctl = ALU_AND;
                    CMD_ORR: dec.alu_ctl = ALU_ORR;
                    default: dec.illegal = 1'b1;
                endcase
                dec.flag_w[1] = funct[0];
                dec.flag_w[0] = funct[0] & ((cmd == CMD_ADD) | (cmd == CMD_SUB));
            end
            OP_MEM: begin
                dec.alu_src = 1'b1;
                dec.imm_src = 2'b01;
                dec.alu_ctl = ALU_ADD;
                if (funct[0]) begin
                    dec.reg_w      = 1'b1;
                    dec.mem_to_reg = 1'b1;
                end else begin
                    dec.mem_w   = 1'b1;
                    dec.reg_src = 2'b10;
                end
            end
            OP_BR: begin
                dec.branch  = 1'b1;
                dec.alu_src = 1'b1;
                dec.imm_src = 2'b10;
                dec.reg_src = 2'b01;
                dec.alu_ctl = ALU_ADD;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (cond == COND_NV) dec.illegal = 1'b1;
        // Illegal encodings present an all-zero decode to the datapath.
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    assign pcs = dec.branch | (dec.reg_w & (rd == 4'hF));
    assign run = (state_q == RUN);

    assign RegSrc     = dec.reg_src;
    assign ImmSrc     = dec.imm_src;
    assign ALUSrc     = dec.alu_src;
    assign ALUControl = dec.alu_ctl;
    assign MemtoReg   = dec.mem_to_reg;
    assign fault      = fault_q;

    cond_logic #(
        .FLAGS_RST(FLAGS_RST)
    ) u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond_i     (cond),
        .flag_w_i   (dec.flag_w),
        .alu_flags_i(ALUFlags),
        .run_i      (run),
        .legal_i    (~dec.illegal),
        .reg_w_i    (dec.reg_w),
        .mem_w_i    (dec.mem_w),
        .pcs_i      (pcs),
        .cond_ex_o  (cond_ex),
        .reg_write_o(RegWrite),
        .mem_write_o(MemWrite),
        .pc_src_o   (PCSrc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (dec.illegal) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                    end
                end
                FAULT: begin
                    state_q <= FAULT;
                    fault_q <= 1'b1;
                end
                default: begin
                    state_q <= FAULT;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] skipped_q, skipped_d;

    always_comb begin
        retired_d = retired_q;
        skipped_d = skipped_q;
        if (run & ~dec.illegal) begin
            if (cond_ex) retired_d = retired_q + 1'b1;
            else         skipped_d = skipped_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            skipped_q <= '0;
        end else begin
            retired_q <= retired_d;
            skipped_q <= skipped_d;
        end
    end

    assign retired_cnt = retired_q;
    assign skipped_cnt = skipped_q;
`else
    logic             unused_cond_ex;
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cond_ex = cond_ex;
    assign unused_cnt     = '0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus randomized
// instruction streams against an architectural reference model.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        ALUSrc;
    logic [1:0]  ALUControl;
    logic        MemtoReg;
    logic        MemWrite;
    logic        PCSrc;
    logic        fault;
`ifdef CTRL_PERF_EN
    logic [31:0] retired_cnt;
    logic [31:0] skipped_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    control_unit #(
        .FLAGS_RST(4'b0000),
        .CNT_W    (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Instr     (Instr),
        .ALUFlags  (ALUFlags),
        .RegSrc    (RegSrc),
        .RegWrite  (RegWrite),
        .ImmSrc    (ImmSrc),
        .ALUSrc    (ALUSrc),
        .ALUControl(ALUControl),
        .MemtoReg  (MemtoReg),
        .MemWrite  (MemWrite),
        .PCSrc     (PCSrc),
        .fault     (fault)
`ifdef CTRL_PERF_EN
        ,
        .retired_cnt(retired_cnt),
        .skipped_cnt(skipped_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state: architectural flags, fault, counters.
    bit [3:0]  m_flags;
    bit        m_fault;
    bit [31:0] m_ret;
    bit [31:0] m_skp;

    typedef struct {
        bit       illegal;
        bit       condex;
        bit       regwrite;
        bit       memwrite;
        bit       pcsrc;
        bit [1:0] regsrc;
        bit [1:0] immsrc;
        bit       alusrc;
        bit [1:0] aluctl;
        bit       memtoreg;
        bit [3:0] nflags;
    } exp_t;

    function automatic bit cond_holds(input int cnd, input bit [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cnd)
            0:  return z;
            1:  return !z;
            2:  return c;
            3:  return !c;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return c && !z;
            9:  return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input bit [31:0] ins, input bit [3:0] af, input bit rst);
        exp_t e;
        int cnd, op, cmd, rd;
        bit imm, s, regw, memw, br, fnz, fcv, en;
        cnd = int'(ins[31:28]); op = int'(ins[27:26]); imm = ins[25];
        cmd = int'(ins[24:21]); s = ins[20]; rd = int'(ins[15:12]);
        e = '{default: 0};
        regw = 0; memw = 0; br = 0; fnz = 0; fcv = 0;
        if (op == 0) begin
            e.illegal = !(cmd == 4 || cmd == 2 || cmd == 0 || cmd == 12);
            regw = 1;
            e.alusrc = imm;
            e.aluctl = (cmd == 4) ? 2'd0 : (cmd == 2) ? 2'd1 : (cmd == 0) ? 2'd2 : 2'd3;
            fnz = s;
            fcv = s && (cmd == 4 || cmd == 2);
        end else if (op == 1) begin
            e.alusrc = 1; e.immsrc = 2'd1; e.aluctl = 2'd0;
            if (s) begin regw = 1; e.memtoreg = 1; end
            else   begin memw = 1; e.regsrc = 2'd2; end
        end else if (op == 2) begin
            br = 1; e.alusrc = 1; e.immsrc = 2'd2; e.regsrc = 2'd1; e.aluctl = 2'd0;
        end else begin
            e.illegal = 1;
        end
        if (cnd == 15) e.illegal = 1;
        if (e.illegal) begin
            e.alusrc = 0; e.immsrc = 0; e.regsrc = 0; e.aluctl = 0; e.memtoreg = 0;
            regw = 0; memw = 0; br = 0; fnz = 0; fcv = 0;
        end
        e.condex   = cond_holds(cnd, m_flags);
        en         = !rst && !m_fault && !e.illegal && e.condex;
        e.regwrite = en && regw;
        e.memwrite = en && memw;
        e.pcsrc    = en && (br || (regw && rd == 15));
        e.nflags   = m_flags;
        if (en && fnz) e.nflags[3:2] = af[3:2];
        if (en && fcv) e.nflags[1:0] = af[1:0];
        return e;
    endfunction

    task automatic model_commit(input bit [31:0] ins, input bit [3:0] af, input bit rst);
        exp_t e;
        e = model(ins, af, rst);
        if (rst) begin
            m_flags = 4'b0000; m_fault = 0; m_ret = 0; m_skp = 0;
        end else if (!m_fault) begin
            if (e.illegal) m_fault = 1;
            else begin
                if (e.condex) m_ret++;
                else          m_skp++;
                m_flags = e.nflags;
            end
        end
    endtask

    task automatic apply(input bit [31:0] ins, input bit [3:0] af, input bit rst);
        @(posedge clk);
        #1;
        Instr    = ins[31:12];
        ALUFlags = af;
        reset    = rst;
        #3;
    endtask

    task automatic test_reset();
        apply(32'hE0921003, 4'b0000, 1'b1);
        n_tests++;
        if (RegWrite !== 1'b0 || MemWrite !== 1'b0 || PCSrc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_enables: got %b%b%b want 000", RegWrite, MemWrite, PCSrc);
        end
        apply(32'hE0921003, 4'b0000, 1'b0);
        n_tests++;
        if (fault !== 1'b0 || RegWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: fault=%b RegWrite=%b want 0/1", fault, RegWrite);
        end
    endtask

    task automatic test_dp_branch();
        apply(32'hE0921003, 4'b0000, 1'b1);
        apply(32'hE0921003, 4'b0100, 1'b0);
        n_tests++;
        if (RegWrite !== 1'b1 || ALUSrc !== 1'b0 || ALUControl !== 2'b00) begin
            n_fail++;
            $display("FAIL adds_decode: rw=%b src=%b ctl=%b want 1 0 00", RegWrite, ALUSrc, ALUControl);
        end
        apply(32'h0A000002, 4'b0000, 1'b0);
        n_tests++;
        if (PCSrc !== 1'b1 || ImmSrc !== 2'b10 || RegSrc !== 2'b01) begin
            n_fail++;
            $display("FAIL beq_taken: pcs=%b imm=%b rsrc=%b want 1 10 01", PCSrc, ImmSrc, RegSrc);
        end
    endtask

    task automatic test_subs_cond();
        apply(32'hE2500001, 4'b0010, 1'b0);
        n_tests++;
        if (ALUControl !== 2'b01 || ALUSrc !== 1'b1) begin
            n_fail++;
            $display("FAIL subs_decode: ctl=%b src=%b want 01 1", ALUControl, ALUSrc);
        end
        apply(32'h0A000002, 4'b0000, 1'b0);
        n_tests++;
        if (PCSrc !== 1'b0 || RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_not_taken: pcs=%b rw=%b want 0 0", PCSrc, RegWrite);
        end
        apply(32'h1A000002, 4'b0000, 1'b0);
        n_tests++;
        if (PCSrc !== 1'b1) begin
            n_fail++;
            $display("FAIL bne_taken: pcs=%b want 1", PCSrc);
        end
        apply(32'h2A000002, 4'b0000, 1'b0);
        n_tests++;
        if (PCSrc !== 1'b1) begin
            n_fail++;
            $display("FAIL bcs_taken: pcs=%b want 1", PCSrc);
        end
    endtask

    task automatic test_mem();
        apply(32'hE5921004, 4'b0000, 1'b0);
        n_tests++;
        if (RegWrite !== 1'b1 || MemtoReg !== 1'b1 || ImmSrc !== 2'b01 || MemWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL ldr: rw=%b m2r=%b imm=%b mw=%b want 1 1 01 0", RegWrite, MemtoReg, ImmSrc, MemWrite);
        end
        apply(32'hE5821004, 4'b0000, 1'b0);
        n_tests++;
        if (MemWrite !== 1'b1 || RegWrite !== 1'b0 || RegSrc !== 2'b10) begin
            n_fail++;
            $display("FAIL str: mw=%b rw=%b rsrc=%b want 1 0 10", MemWrite, RegWrite, RegSrc);
        end
    endtask

    task automatic test_fault();
        apply(32'hE1A0F00E, 4'b0000, 1'b0);
        n_tests++;
        if (RegWrite !== 1'b0 || PCSrc !== 1'b0 || fault !== 1'b0 || ALUSrc !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_cycle: rw=%b pcs=%b fault=%b src=%b want 0 0 0 0", RegWrite, PCSrc, fault, ALUSrc);
        end
        apply(32'hE0921003, 4'b0000, 1'b0);
        n_tests++;
        if (fault !== 1'b1 || RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_held: fault=%b rw=%b want 1 0", fault, RegWrite);
        end
        apply(32'hE5821004, 4'b0000, 1'b0);
        n_tests++;
        if (MemWrite !== 1'b0 || RegSrc !== 2'b10) begin
            n_fail++;
            $display("FAIL fault_str: mw=%b rsrc=%b want 0 10", MemWrite, RegSrc);
        end
        apply(32'hE0921003, 4'b0000, 1'b1);
        apply(32'hE0921003, 4'b0000, 1'b0);
        n_tests++;
        if (fault !== 1'b0 || RegWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_cleared: fault=%b rw=%b want 0 1", fault, RegWrite);
        end
        apply(32'hF0921003, 4'b0000, 1'b0);
        n_tests++;
        if (RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL cond_nv_illegal: rw=%b want 0", RegWrite);
        end
        apply(32'hE0921003, 4'b0000, 1'b0);
        n_tests++;
        if (fault !== 1'b1) begin
            n_fail++;
            $display("FAIL cond_nv_fault: fault=%b want 1", fault);
        end
    endtask

    task automatic test_flags();
        apply(32'hE0921003, 4'b0000, 1'b1);
        apply(32'hE0921003, 4'b1000, 1'b0);
        apply(32'hE0021003, 4'b0111, 1'b0);
        apply(32'h4A000002, 4'b0000, 1'b0);
        n_tests++;
        if (PCSrc !== 1'b1) begin
            n_fail++;
            $display("FAIL and_no_s_keeps_n: pcs=%b want 1", PCSrc);
        end
        apply(32'h0A000002, 4'b0000, 1'b0);
        n_tests++;
        if (PCSrc !== 1'b0) begin
            n_fail++;
            $display("FAIL and_no_s_keeps_z: pcs=%b want 0", PCSrc);
        end
        apply(32'hE0921003, 4'b0111, 1'b0);
        apply(32'h6A000002, 4'b0000, 1'b0);
        n_tests++;
        if (PCSrc !== 1'b1) begin
            n_fail++;
            $display("FAIL adds_sets_v: pcs=%b want 1", PCSrc);
        end
        apply(32'h4A000002, 4'b0000, 1'b0);
        n_tests++;
        if (PCSrc !== 1'b0) begin
            n_fail++;
            $display("FAIL adds_clears_n: pcs=%b want 0", PCSrc);
        end
        apply(32'hC2800001, 4'b0000, 1'b0);
        n_tests++;
        if (RegWrite !== 1'b0 || ALUSrc !== 1'b1) begin
            n_fail++;
            $display("FAIL addgt_skip: rw=%b src=%b want 0 1", RegWrite, ALUSrc);
        end
        apply(32'hD2800001, 4'b0000, 1'b0);
        n_tests++;
        if (RegWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL addle_exec: rw=%b want 1", RegWrite);
        end
    endtask

`ifdef CTRL_PERF_EN
    task automatic test_perf();
        apply(32'hE0821003, 4'b0000, 1'b1);
        apply(32'hE0821003, 4'b0000, 1'b0);
        apply(32'h0A000002, 4'b0000, 1'b0);
        apply(32'hE0821003, 4'b0000, 1'b0);
        apply(32'h0A000002, 4'b0000, 1'b0);
        apply(32'hE0821003, 4'b0000, 1'b0);
        apply(32'hE0821003, 4'b0000, 1'b1);
        n_tests++;
        if (retired_cnt !== 32'd3 || skipped_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_counts: ret=%0d skp=%0d want 3 2", retired_cnt, skipped_cnt);
        end
        apply(32'hE0821003, 4'b0000, 1'b0);
        n_tests++;
        if (retired_cnt !== 32'd0 || skipped_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset: ret=%0d skp=%0d want 0 0", retired_cnt, skipped_cnt);
        end
    endtask
`endif

    function automatic bit [31:0] rand_instr();
        bit [31:0] ins;
        bit [3:0]  cmds [4] = '{4'h4, 4'h2, 4'h0, 4'hC};
        int        kind;
        ins = $urandom;
        ins[31:28] = ($urandom_range(0, 24) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        kind = $urandom_range(0, 19);
        if (kind < 8) begin
            ins[27:26] = 2'b00;
            ins[24:21] = cmds[$urandom_range(0, 3)];
        end else if (kind < 12) begin
            ins[27:26] = 2'b01;
        end else if (kind < 17) begin
            ins[27:26] = 2'b10;
        end else if (kind < 19) begin
            ins[27:26] = 2'b00;
        end else begin
            ins[27:26] = 2'b11;
        end
        return ins;
    endfunction

    task automatic test_random();
        bit [31:0] ins;
        bit [3:0]  af;
        bit        rst;
        exp_t      e;
        m_flags = 0; m_fault = 0; m_ret = 0; m_skp = 0;
        apply(32'hE0821003, 4'b0000, 1'b1);
        model_commit(32'hE0821003, 4'b0000, 1'b1);
        for (int i = 0; i < 400; i++) begin
            ins = rand_instr();
            af  = 4'($urandom);
            rst = ($urandom_range(0, 14) == 0);
            apply(ins, af, rst);
            e = model(ins, af, rst);
            n_tests++;
            if (RegWrite !== e.regwrite || MemWrite !== e.memwrite || PCSrc !== e.pcsrc) begin
                n_fail++;
                $display("FAIL rnd_enables i=%0d ins=%h: got %b%b%b want %b%b%b", i, ins,
                         RegWrite, MemWrite, PCSrc, e.regwrite, e.memwrite, e.pcsrc);
            end
            n_tests++;
            if (RegSrc !== e.regsrc || ImmSrc !== e.immsrc || ALUSrc !== e.alusrc ||
                ALUControl !== e.aluctl || MemtoReg !== e.memtoreg) begin
                n_fail++;
                $display("FAIL rnd_decode i=%0d ins=%h: got %b %b %b %b %b want %b %b %b %b %b",
                         i, ins, RegSrc, ImmSrc, ALUSrc, ALUControl, MemtoReg,
                         e.regsrc, e.immsrc, e.alusrc, e.aluctl, e.memtoreg);
            end
            n_tests++;
            if (fault !== m_fault) begin
                n_fail++;
                $display("FAIL rnd_fault i=%0d: got %b want %b", i, fault, m_fault);
            end
`ifdef CTRL_PERF_EN
            n_tests++;
            if (retired_cnt !== m_ret || skipped_cnt !== m_skp) begin
                n_fail++;
                $display("FAIL rnd_perf i=%0d: got %0d/%0d want %0d/%0d", i,
                         retired_cnt, skipped_cnt, m_ret, m_skp);
            end
`endif
            model_commit(ins, af, rst);
        end
    endtask

    initial begin
        reset    = 1'b1;
        Instr    = '0;
        ALUFlags = '0;
        test_reset();
        test_dp_branch();
        test_subs_cond();
        test_mem();
        test_fault();
        test_flags();
`ifdef CTRL_PERF_EN
        test_perf();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
